// File: rtl/pcx2mb_sm.sv
// -----------------------------------------------------------------------------
// pcx2mb_sm
// PCX-side serializer of the SPARC-to-MicroBlaze bridge. PCX requests from the
// core are captured in two stages (PQ: destination/atomic, PA: payload) into a
// 2-entry buffer. Each entry is formatted as a 128-bit frame
// {atom, dest_idx[2:0], payload} and written MSB-first as four 32-bit words to
// the FSL master port. Once the last word of a frame has been written, the
// core receives a one-cycle grant on that frame's destination bit.
//
// Ports:
//   rclk               clock, all logic on posedge
//   reset              asynchronous active-high reset
//   spc_pcx_req_pq     one-hot destination request (PQ cycle)
//   spc_pcx_atom_pq    atomic marker, qualified by a nonzero request
//   spc_pcx_data_pa    packet payload, valid the cycle after the request
//   pcx_spc_grant_px   one-cycle grant pulse on the frame's destination bit
//   fsl_pcx_m_write    FSL write strobe
//   fsl_pcx_m_data     FSL write data
//   fsl_pcx_m_control  high on word 0 of each frame
//   fsl_pcx_m_full     FSL FIFO full; no write while high
//
// Handshake: a word transfers on every cycle where fsl_pcx_m_write is high;
// write is only raised while fsl_pcx_m_full is low, and data/control hold
// their values while full stalls the frame.
// -----------------------------------------------------------------------------
module pcx2mb_sm #(
    parameter int PCX_WIDTH      = 124,
    parameter int FSL_D_WIDTH    = 32,
    parameter int PCX_GEAR_RATIO = 4
) (
    input  logic                   rclk,
    input  logic                   reset,
    input  logic [4:0]             spc_pcx_req_pq,
    input  logic                   spc_pcx_atom_pq,
    input  logic [PCX_WIDTH-1:0]   spc_pcx_data_pa,
    output logic [4:0]             pcx_spc_grant_px,
    output logic                   fsl_pcx_m_write,
    output logic [FSL_D_WIDTH-1:0] fsl_pcx_m_data,
    output logic                   fsl_pcx_m_control,
    input  logic                   fsl_pcx_m_full
);

    localparam int FW = PCX_WIDTH + 4;
    localparam int CW = $clog2(PCX_GEAR_RATIO);
    localparam logic [CW-1:0] LAST_CNT = CW'(PCX_GEAR_RATIO - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b01,
        ST_SEND = 2'b10
    } state_t;

    state_t         r_state, w_state_nxt;
    logic           r_pq_vld;
    logic           r_pq_atom;
    logic [2:0]     r_pq_dest;
    logic [2:0]     w_req_idx;
    logic [FW-1:0]  r_buf [2];
    logic           r_wr_ptr, r_rd_ptr;
    logic [1:0]     r_occ;
    logic [FW-1:0]  r_shreg;
    logic [CW-1:0]  r_cnt;
    logic [4:0]     r_grant;
    logic [FW-1:0]  w_enq_data;
    logic [FW-1:0]  w_load_data;
    logic           w_load;
    logic           w_enq;
    logic           w_deq;
    logic           w_write;
    logic [2:0]     w_deq_dest;

    // Lowest set request bit wins if the core ever drives a multi-hot request.
    always_comb begin
        w_req_idx = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (spc_pcx_req_pq[i]) w_req_idx = 3'(i);
        end
    end

    assign w_enq_data = {r_pq_atom, r_pq_dest, spc_pcx_data_pa};
    assign w_write    = (r_state == ST_SEND) && !fsl_pcx_m_full;
    assign w_deq      = w_write && (r_cnt == '0);
    // A full buffer still accepts a packet if the head leaves this cycle.
    assign w_enq      = r_pq_vld && ((r_occ != 2'd2) || w_deq);
    // The head entry stays in the buffer until its last word is written, so
    // its destination is read from the buffer rather than from the shifter.
    assign w_deq_dest = r_buf[r_rd_ptr][FW-2 -: 3];

    assign fsl_pcx_m_write   = w_write;
    assign fsl_pcx_m_data    = (r_state == ST_SEND) ? r_shreg[FW-1 -: FSL_D_WIDTH] : '0;
    assign fsl_pcx_m_control = w_write && (r_cnt == LAST_CNT);
    assign pcx_spc_grant_px  = r_grant;

    // Next-state and shifter-load selection. A packet arriving in its PA cycle
    // can be loaded straight into the shifter (bypass) when nothing older is
    // waiting, both from IDLE and on the last word of the previous frame.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_data = r_buf[r_rd_ptr];
        case (r_state)
            ST_IDLE: begin
                if (r_occ != 2'd0) begin
                    w_load      = 1'b1;
                    w_load_data = r_buf[r_rd_ptr];
                    w_state_nxt = ST_SEND;
                end else if (w_enq) begin
                    w_load      = 1'b1;
                    w_load_data = w_enq_data;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_deq) begin
                    if (r_occ == 2'd2) begin
                        w_load      = 1'b1;
                        w_load_data = r_buf[~r_rd_ptr];
                    end else if (w_enq) begin
                        w_load      = 1'b1;
                        w_load_data = w_enq_data;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge rclk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_pq_vld  <= 1'b0;
            r_pq_atom <= 1'b0;
            r_pq_dest <= 3'd0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_occ     <= 2'd0;
            r_shreg   <= '0;
            r_cnt     <= '0;
            r_grant   <= 5'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_pq_vld  <= |spc_pcx_req_pq;
            r_pq_atom <= spc_pcx_atom_pq;
            r_pq_dest <= w_req_idx;

            if (w_enq) r_wr_ptr <= ~r_wr_ptr;
            if (w_deq) r_rd_ptr <= ~r_rd_ptr;
            case ({w_enq, w_deq})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase

            if (w_load) begin
                r_shreg <= w_load_data;
                r_cnt   <= LAST_CNT;
            end else if (w_write) begin
                r_shreg <= r_shreg << FSL_D_WIDTH;
                r_cnt   <= r_cnt - CW'(1);
            end

            r_grant <= w_deq ? 5'(5'b00001 << w_deq_dest) : 5'd0;
        end
    end

    // Buffer storage needs no reset; occupancy decides what is valid.
    always_ff @(posedge rclk) begin
        if (w_enq) r_buf[r_wr_ptr] <= w_enq_data;
    end

endmodule

// File: tb/tb_pcx2mb_sm.sv
module tb_pcx2mb_sm;

    localparam logic [123:0] D1 = 124'h0123456789ABCDEF0123456789ABCDE;
    localparam logic [123:0] D2 = 124'hFEDCBA9876543210FEDCBA987654321;

    typedef struct {
        logic [4:0]   req;
        logic         atom;
        logic [123:0] data;
        logic         full;
        logic         wr;
        logic         chk_d;
        logic [31:0]  d;
        logic         ctl;
        logic [4:0]   gr;
    } vec_t;

    logic         rclk;
    logic         reset;
    logic [4:0]   spc_pcx_req_pq;
    logic         spc_pcx_atom_pq;
    logic [123:0] spc_pcx_data_pa;
    logic [4:0]   pcx_spc_grant_px;
    logic         fsl_pcx_m_write;
    logic [31:0]  fsl_pcx_m_data;
    logic         fsl_pcx_m_control;
    logic         fsl_pcx_m_full;

    int    n_checks = 0;
    int    n_errors = 0;
    string cur_test = "reset";
    vec_t  vecs[$];

    pcx2mb_sm dut (
        .rclk              (rclk),
        .reset             (reset),
        .spc_pcx_req_pq    (spc_pcx_req_pq),
        .spc_pcx_atom_pq   (spc_pcx_atom_pq),
        .spc_pcx_data_pa   (spc_pcx_data_pa),
        .pcx_spc_grant_px  (pcx_spc_grant_px),
        .fsl_pcx_m_write   (fsl_pcx_m_write),
        .fsl_pcx_m_data    (fsl_pcx_m_data),
        .fsl_pcx_m_control (fsl_pcx_m_control),
        .fsl_pcx_m_full    (fsl_pcx_m_full)
    );

    // Clock / reset
    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s.%s row %0d: got %0h expected %0h", cur_test, name, idx, act, exp);
        end
    endtask

    // Driver: one table row per clock cycle. Inputs change on the falling
    // edge and outputs are sampled 1 time unit later, well away from posedge.
    task automatic add(input logic [4:0] req, input logic atom, input logic [123:0] data,
                       input logic full, input logic wr, input logic chk_d,
                       input logic [31:0] d, input logic ctl, input logic [4:0] gr);
        vec_t v;
        v.req = req; v.atom = atom; v.data = data; v.full = full;
        v.wr = wr; v.chk_d = chk_d; v.d = d; v.ctl = ctl; v.gr = gr;
        vecs.push_back(v);
    endtask

    task automatic w(input logic [31:0] d, input logic ctl, input logic [4:0] gr);
        add(5'd0, 1'b0, '0, 1'b0, 1'b1, 1'b1, d, ctl, gr);
    endtask

    task automatic stall(input logic [31:0] d);
        add(5'd0, 1'b0, '0, 1'b1, 1'b0, 1'b1, d, 1'b0, 5'd0);
    endtask

    task automatic idle(input logic [4:0] gr);
        add(5'd0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, gr);
    endtask

    task automatic req_only(input logic [4:0] req, input logic atom);
        add(req, atom, '0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 5'd0);
    endtask

    task automatic data_only(input logic [123:0] data);
        add(5'd0, 1'b0, data, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 5'd0);
    endtask

    task automatic run_vecs(input string name);
        cur_test = name;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge rclk);
            spc_pcx_req_pq  = vecs[i].req;
            spc_pcx_atom_pq = vecs[i].atom;
            spc_pcx_data_pa = vecs[i].data;
            fsl_pcx_m_full  = vecs[i].full;
            #1;
            chk("write", i, 32'(fsl_pcx_m_write), 32'(vecs[i].wr));
            chk("control", i, 32'(fsl_pcx_m_control), 32'(vecs[i].ctl));
            chk("grant", i, 32'(pcx_spc_grant_px), 32'(vecs[i].gr));
            if (vecs[i].chk_d) chk("data", i, fsl_pcx_m_data, vecs[i].d);
        end
        vecs.delete();
    endtask

    initial begin
        reset           = 1'b1;
        spc_pcx_req_pq  = 5'd0;
        spc_pcx_atom_pq = 1'b0;
        spc_pcx_data_pa = '0;
        fsl_pcx_m_full  = 1'b0;
        #3;
        chk("write", 0, 32'(fsl_pcx_m_write), 32'd0);
        chk("control", 0, 32'(fsl_pcx_m_control), 32'd0);
        chk("grant", 0, 32'(pcx_spc_grant_px), 32'd0);
        chk("data", 0, fsl_pcx_m_data, 32'd0);
        repeat (2) @(negedge rclk);
        reset = 1'b0;

        // Single packet, dest 2: frame header nibble 4'h2.
        req_only(5'b00100, 1'b0);
        data_only(D1);
        w(32'h20123456, 1'b1, 5'd0);
        w(32'h789ABCDE, 1'b0, 5'd0);
        w(32'hF0123456, 1'b0, 5'd0);
        w(32'h789ABCDE, 1'b0, 5'd0);
        idle(5'b00100);
        idle(5'd0);
        run_vecs("single");

        // Back-pressure on words 1..3; data must hold while stalled.
        req_only(5'b00100, 1'b0);
        data_only(D1);
        w(32'h20123456, 1'b1, 5'd0);
        stall(32'h789ABCDE);
        stall(32'h789ABCDE);
        stall(32'h789ABCDE);
        w(32'h789ABCDE, 1'b0, 5'd0);
        w(32'hF0123456, 1'b0, 5'd0);
        w(32'h789ABCDE, 1'b0, 5'd0);
        idle(5'b00100);
        idle(5'd0);
        run_vecs("backpressure");

        // Atomic pair to dest 0: header nibble 4'h8, frames back-to-back.
        req_only(5'b00001, 1'b1);
        add(5'b00001, 1'b1, D2, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 5'd0);
        add(5'd0, 1'b0, D1, 1'b0, 1'b1, 1'b1, 32'h8FEDCBA9, 1'b1, 5'd0);
        w(32'h87654321, 1'b0, 5'd0);
        w(32'h0FEDCBA9, 1'b0, 5'd0);
        w(32'h87654321, 1'b0, 5'd0);
        w(32'h80123456, 1'b1, 5'b00001);
        w(32'h789ABCDE, 1'b0, 5'd0);
        w(32'hF0123456, 1'b0, 5'd0);
        w(32'h789ABCDE, 1'b0, 5'd0);
        idle(5'b00001);
        idle(5'd0);
        run_vecs("atomic");

        // Overflow: third packet arrives with two buffered and FSL full.
        add(5'b00100, 1'b0, '0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 5'd0);
        add(5'b00001, 1'b1, D1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 5'd0);
        add(5'b10000, 1'b0, D2, 1'b1, 1'b0, 1'b1, 32'h20123456, 1'b0, 5'd0);
        add(5'd0, 1'b0, D1, 1'b1, 1'b0, 1'b1, 32'h20123456, 1'b0, 5'd0);
        stall(32'h20123456);
        w(32'h20123456, 1'b1, 5'd0);
        w(32'h789ABCDE, 1'b0, 5'd0);
        w(32'hF0123456, 1'b0, 5'd0);
        w(32'h789ABCDE, 1'b0, 5'd0);
        w(32'h8FEDCBA9, 1'b1, 5'b00100);
        w(32'h87654321, 1'b0, 5'd0);
        w(32'h0FEDCBA9, 1'b0, 5'd0);
        w(32'h87654321, 1'b0, 5'd0);
        idle(5'b00001);
        idle(5'd0);
        idle(5'd0);
        idle(5'd0);
        run_vecs("overflow");

        // Next packet's PA lands on the previous frame's last word
        // (enqueue and dequeue together, bypass reload). Dest 3: nibble 4'h3.
        req_only(5'b00100, 1'b0);
        data_only(D1);
        w(32'h20123456, 1'b1, 5'd0);
        w(32'h789ABCDE, 1'b0, 5'd0);
        add(5'b01000, 1'b0, '0, 1'b0, 1'b1, 1'b1, 32'hF0123456, 1'b0, 5'd0);
        add(5'd0, 1'b0, D2, 1'b0, 1'b1, 1'b1, 32'h789ABCDE, 1'b0, 5'd0);
        w(32'h3FEDCBA9, 1'b1, 5'b00100);
        w(32'h87654321, 1'b0, 5'd0);
        w(32'h0FEDCBA9, 1'b0, 5'd0);
        w(32'h87654321, 1'b0, 5'd0);
        idle(5'b01000);
        idle(5'd0);
        run_vecs("backtoback");

        // Multi-hot request: lowest bit (1) wins, header nibble 4'h1.
        req_only(5'b10010, 1'b0);
        data_only(D2);
        w(32'h1FEDCBA9, 1'b1, 5'd0);
        w(32'h87654321, 1'b0, 5'd0);
        w(32'h0FEDCBA9, 1'b0, 5'd0);
        w(32'h87654321, 1'b0, 5'd0);
        idle(5'b00010);
        idle(5'd0);
        run_vecs("multihot");

        // Reset mid-frame: abort after word 1, no grant for the aborted frame.
        req_only(5'b00100, 1'b0);
        data_only(D1);
        w(32'h20123456, 1'b1, 5'd0);
        w(32'h789ABCDE, 1'b0, 5'd0);
        run_vecs("reset_pre");
        cur_test = "reset_mid";
        reset = 1'b1;
        #1;
        chk("write", 0, 32'(fsl_pcx_m_write), 32'd0);
        chk("grant", 0, 32'(pcx_spc_grant_px), 32'd0);
        chk("control", 0, 32'(fsl_pcx_m_control), 32'd0);
        chk("data", 0, fsl_pcx_m_data, 32'd0);
        repeat (2) @(negedge rclk);
        reset = 1'b0;
        idle(5'd0);
        idle(5'd0);
        idle(5'd0);
        req_only(5'b00001, 1'b0);
        data_only(D2);
        w(32'h0FEDCBA9, 1'b1, 5'd0);
        w(32'h87654321, 1'b0, 5'd0);
        w(32'h0FEDCBA9, 1'b0, 5'd0);
        w(32'h87654321, 1'b0, 5'd0);
        idle(5'b00001);
        idle(5'd0);
        run_vecs("reset_post");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pcx2mb_sm.md
Name: pcx2mb_sm

Overview:
- PCX-side serializer of the SPARC-to-MicroBlaze bridge. It is the request-direction neighbour of the FSL-to-CPX return stage.
- Accepts PCX packets from the SPARC core into a 2-entry buffer. Formats each packet as a 128-bit frame and writes it MSB-first as four 32-bit words to the FSL master port.
- Returns a PCX grant to the core once the frame's last word has been written.

Parameters:
- PCX_WIDTH, 124: PCX payload width.
- FSL_D_WIDTH, 32: FSL data word width.
- PCX_GEAR_RATIO, 4: words per frame, equal to (PCX_WIDTH+4)/FSL_D_WIDTH.

Ports:
- rclk  in  1  clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- spc_pcx_req_pq  in  5  one-hot destination request, PQ cycle.
- spc_pcx_atom_pq  in  1  atomic marker, qualified by a nonzero req.
- spc_pcx_data_pa  in  124  packet payload, valid the cycle after req (PA).
- pcx_spc_grant_px  out  5  one-cycle grant pulse on the packet's destination bit.
- fsl_pcx_m_write  out  1  FSL write strobe.
- fsl_pcx_m_data  out  32  FSL write data.
- fsl_pcx_m_control  out  1  high on word 0 of each frame only.
- fsl_pcx_m_full  in  1  FSL FIFO full; no write is permitted while high.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - Outputs: grant=0, write=0, data=0, control=0.
  - Internal: buffer empty, pointers=0, state=IDLE, word count=0, PA pipeline cleared.
  - An in-flight frame is discarded with no grant. Operation resumes on the first rclk edge after reset deasserts.
- PQ capture: when req!=0 in cycle N, register dest_idx, atom and a valid bit.
  - dest_idx = binary index (0..4) of the lowest set req bit. Multi-hot req is illegal; lowest index wins.
- PA capture, cycle N+1: write {atom, dest_idx[2:0], spc_pcx_data_pa} (128 bits) to the buffer entry at the write pointer.
- Atomic: core issues two packets with req in consecutive cycles, both with atom=1. Each is handled as a separate frame with its own grant; no special pairing logic.
- Buffer:
  - 2 entries, wr/rd pointers wrap 1->0, occupancy count 0..2.
  - Enqueue and dequeue in the same cycle are allowed; occupancy is unchanged.
  - Enqueue when occupancy=2 with no same-cycle dequeue: the packet is dropped, no grant is issued, and pointers are unchanged. The core's 2-credit rule makes this an error case.
- State machine, one-hot {IDLE, SEND}:
  - IDLE: if buffer non-empty, load the head entry into a 128-bit shift register, set count=3, go to SEND.
  - The load may occur in the same cycle as the entry's PA capture (bypass), so the first word can write at N+2.
  - SEND, each cycle:
    - If full=0: write=1, data=shreg[127:96], control=(count==3).
    - If full=1: write=0, and shreg and count hold.
  - On a write with count!=0: shift left 32, decrement count.
  - On the write with count==0:
    - Dequeue the buffer head.
    - Next cycle, pulse grant on bit dest_idx of the frame just sent.
    - If another entry is present (after this cycle's enqueue), reload and stay in SEND with count=3, so frames go back-to-back with no idle cycle. Otherwise go to IDLE.
- Output registering: write, data and control are combinational from state, count, shreg and full. shreg and count are registered.
- Data must be stable while full holds off a write.
- Latency, empty and idle, full=0: req at N, words at N+2..N+5, grant at N+6.
- Grant is exactly one pulse per sent frame, never more than one bit set.

Test Plan:
- Single packet: req=5'b00100, atom=0 at N, data=124'h0123…ABCD at N+1, full=0 → write at N+2..N+5.
  - Word0 = {1'b0,3'd2,data[123:96]} with control=1; words 1..3 = data[95:0] MSB-first with control=0.
  - grant=5'b00100 at N+6 only.
- Back-pressure: same packet, full high at N+3..N+5 → words 1..3 delayed 3 cycles and unchanged; no write while full; grant one cycle after word 3.
- Atomic pair: req=5'b00001, atom=1 at N and N+1 → 8 consecutive words with control at N+2 and N+6; word0 MSB=1 both times; grants at N+6 and N+10.
- Overflow: three reqs at N, N+1, N+2 with full held high → the third is dropped; after full releases, exactly two frames and two grants.
- Reset mid-frame: assert reset after word 1 → write=0 and grant=0 immediately; after release the next packet starts with control=1 word0, and no grant is issued for the aborted frame.
- Multi-hot req=5'b10010 → dest_idx=1, grant=5'b00010.
